// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (IF, LS) and memory-side signals for the unified memory port arbiter.
// The slave modport is the arbiter's view; master is the view of the surrounding pipeline and memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int STRB_W = DATA_W / 8;

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_flush_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              ls_req_i;
  logic              ls_we_i;
  logic [ADDR_W-1:0] ls_addr_i;
  logic [DATA_W-1:0] ls_wdata_i;
  logic [STRB_W-1:0] ls_wstrb_i;
  logic              ls_gnt_o;
  logic              ls_rvalid_o;
  logic [DATA_W-1:0] ls_rdata_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [STRB_W-1:0] mem_wstrb_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wstrb_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wstrb_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and load/store,
// LS-priority with a starvation limit that forces an IF win after STARVE_MAX consecutive IF losses.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no transaction; arbitrate, grant combinationally
// S_REQ  | mem_req_o high with latched payload until mem_gnt_i
// S_WAIT | request accepted; wait for mem_rvalid_i, then return to idle
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int         STRB_W     = DATA_W / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_t;

  state_t            state;
  owner_t            owner;
  logic [3:0]        starve_cnt;
  logic              kill;
  logic              mem_req;
  logic              pay_we;
  logic [ADDR_W-1:0] pay_addr;
  logic [DATA_W-1:0] pay_wdata;
  logic [STRB_W-1:0] pay_wstrb;

  logic starving;
  logic ls_win;
  logic if_win;
  logic resp;
  logic if_resp;
  logic ls_resp;

  // Grants and responses are gated by rst so every output is quiet during reset.
  always_comb begin
    starving = bus.if_req_i && (starve_cnt == STARVE_LIM);
    ls_win   = !rst && (state == S_IDLE) && bus.ls_req_i && !starving;
    if_win   = !rst && (state == S_IDLE) && bus.if_req_i && !ls_win;
    resp     = !rst && (state == S_WAIT) && bus.mem_rvalid_i;
    // A flush arriving in the response cycle itself also suppresses the stale fetch data.
    if_resp  = resp && (owner == OWN_IF) && !kill && !bus.if_flush_i;
    ls_resp  = resp && (owner == OWN_LS);
  end

  assign bus.if_gnt_o    = if_win;
  assign bus.ls_gnt_o    = ls_win;
  assign bus.if_rvalid_o = if_resp;
  assign bus.ls_rvalid_o = ls_resp;
  assign bus.if_rdata_o  = if_resp ? bus.mem_rdata_i : '0;
  assign bus.ls_rdata_o  = ls_resp ? bus.mem_rdata_i : '0;

  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = pay_we;
  assign bus.mem_addr_o  = pay_addr;
  assign bus.mem_wdata_o = pay_wdata;
  assign bus.mem_wstrb_o = pay_wstrb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= OWN_NONE;
      starve_cnt <= '0;
      kill       <= 1'b0;
      mem_req    <= 1'b0;
      pay_we     <= 1'b0;
      pay_addr   <= '0;
      pay_wdata  <= '0;
      pay_wstrb  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ls_win) begin
            if (bus.if_req_i && (starve_cnt != STARVE_LIM)) starve_cnt <= starve_cnt + 4'd1;
            owner     <= OWN_LS;
            state     <= S_REQ;
            mem_req   <= 1'b1;
            pay_we    <= bus.ls_we_i;
            pay_addr  <= bus.ls_addr_i;
            pay_wdata <= bus.ls_wdata_i;
            pay_wstrb <= bus.ls_wstrb_i;
          end else if (if_win) begin
            starve_cnt <= '0;
            owner      <= OWN_IF;
            state      <= S_REQ;
            mem_req    <= 1'b1;
            pay_we     <= 1'b0;
            pay_addr   <= bus.if_addr_i;
            pay_wdata  <= '0;
            pay_wstrb  <= '0;
          end
        end
        S_REQ: begin
          if ((owner == OWN_IF) && bus.if_flush_i) kill <= 1'b1;
          if (bus.mem_gnt_i) begin
            state   <= S_WAIT;
            mem_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if ((owner == OWN_IF) && bus.if_flush_i) kill <= 1'b1;
          if (bus.mem_rvalid_i) begin
            state     <= S_IDLE;
            owner     <= OWN_NONE;
            kill      <= 1'b0;
            pay_we    <= 1'b0;
            pay_addr  <= '0;
            pay_wdata <= '0;
            pay_wstrb <= '0;
          end
        end
        default: begin
          state   <= S_IDLE;
          owner   <= OWN_NONE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model of the port.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 64;
  localparam int DATA_W     = 64;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // One in-flight transaction as the model sees it.
  typedef struct packed {
    bit          valid;
    bit          is_ls;
    bit          accepted;
    bit          killed;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } txn_t;

  txn_t cur = '0;
  int   if_losses = 0;
  bit   g_if = 1'b0;
  bit   g_ls = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ls_wins();
    return !cur.valid && bus.ls_req_i && !(bus.if_req_i && if_losses == STARVE_MAX);
  endfunction

  // Model update at the active edge.
  always @(posedge clk) begin
    if (rst) begin
      cur       = '0;
      if_losses = 0;
    end else if (!cur.valid) begin
      if (ls_wins()) begin
        if (bus.if_req_i && if_losses < STARVE_MAX) if_losses++;
        cur = '{valid: 1'b1, is_ls: 1'b1, accepted: 1'b0, killed: 1'b0, we: bus.ls_we_i,
                addr: bus.ls_addr_i, wdata: bus.ls_wdata_i, wstrb: bus.ls_wstrb_i};
      end else if (bus.if_req_i) begin
        if_losses = 0;
        cur = '{valid: 1'b1, is_ls: 1'b0, accepted: 1'b0, killed: 1'b0, we: 1'b0,
                addr: bus.if_addr_i, wdata: 64'h0, wstrb: 8'h0};
      end
    end else begin
      if (!cur.is_ls && bus.if_flush_i) cur.killed = 1'b1;
      if (!cur.accepted) begin
        if (bus.mem_gnt_i) cur.accepted = 1'b1;
      end else if (bus.mem_rvalid_i) begin
        cur = '0;
      end
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    bit          lsw, e_if_gnt, e_ls_gnt, resp, e_if_rv, e_ls_rv;
    logic [63:0] e_if_rd, e_ls_rd;
    lsw      = ls_wins();
    e_ls_gnt = !rst && lsw;
    e_if_gnt = !rst && !cur.valid && bus.if_req_i && !lsw;
    resp     = !rst && cur.valid && cur.accepted && bus.mem_rvalid_i;
    e_if_rv  = resp && !cur.is_ls && !cur.killed && !bus.if_flush_i;
    e_ls_rv  = resp && cur.is_ls;
    e_if_rd  = e_if_rv ? bus.mem_rdata_i : 64'h0;
    e_ls_rd  = e_ls_rv ? bus.mem_rdata_i : 64'h0;
    chk("if_gnt", bus.if_gnt_o, e_if_gnt);
    chk("ls_gnt", bus.ls_gnt_o, e_ls_gnt);
    chk("if_rvalid", bus.if_rvalid_o, e_if_rv);
    chk("ls_rvalid", bus.ls_rvalid_o, e_ls_rv);
    chk("if_rdata", bus.if_rdata_o, e_if_rd);
    chk("ls_rdata", bus.ls_rdata_o, e_ls_rd);
    chk("mem_req", bus.mem_req_o, cur.valid && !cur.accepted);
    if (!cur.valid) begin
      chk("idle_we", bus.mem_we_o, 0);
      chk("idle_addr", bus.mem_addr_o, 0);
      chk("idle_wdata", bus.mem_wdata_o, 0);
      chk("idle_wstrb", bus.mem_wstrb_o, 0);
    end else if (!cur.accepted) begin
      chk("req_we", bus.mem_we_o, cur.we);
      chk("req_addr", bus.mem_addr_o, cur.addr);
      chk("req_wstrb", bus.mem_wstrb_o, cur.wstrb);
      if (cur.we) chk("req_wdata", bus.mem_wdata_o, cur.wdata);
    end
    g_if = e_if_gnt;
    g_ls = e_ls_gnt;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.if_req_i     = 1'b0;
    bus.if_addr_i    = '0;
    bus.if_flush_i   = 1'b0;
    bus.ls_req_i     = 1'b0;
    bus.ls_we_i      = 1'b0;
    bus.ls_addr_i    = '0;
    bus.ls_wdata_i   = '0;
    bus.ls_wstrb_i   = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
  endtask

  initial begin
    logic [9:0] seq;
    int         ng;
    clear_in();
    rst = 1'b1;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 64'h1000;
    @(negedge clk);
    chk("rst_if_gnt", bus.if_gnt_o, 0);
    chk("rst_mem_req", bus.mem_req_o, 0);
    tick();
    rst = 1'b0;
    bus.mem_gnt_i = 1'b1;

    // single IF read
    @(negedge clk);
    chk("t1_if_gnt", bus.if_gnt_o, 1);
    chk("t1_ls_gnt", bus.ls_gnt_o, 0);
    tick();
    bus.if_req_i = 1'b0;
    @(negedge clk);
    chk("t1_mem_req", bus.mem_req_o, 1);
    chk("t1_mem_addr", bus.mem_addr_o, 64'h1000);
    chk("t1_mem_we", bus.mem_we_o, 0);
    tick();
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 64'hDEADBEEF;
    @(negedge clk);
    chk("t1_if_rvalid", bus.if_rvalid_o, 1);
    chk("t1_if_rdata", bus.if_rdata_o, 64'hDEADBEEF);
    chk("t1_ls_rvalid", bus.ls_rvalid_o, 0);
    tick();
    clear_in();
    @(negedge clk);
    chk("t1_idle_req", bus.mem_req_o, 0);
    tick();

    // LS store against a stalled memory
    bus.ls_req_i   = 1'b1;
    bus.ls_we_i    = 1'b1;
    bus.ls_addr_i  = 64'h2008;
    bus.ls_wdata_i = 64'h55;
    bus.ls_wstrb_i = 8'h0F;
    @(negedge clk);
    chk("t2_ls_gnt", bus.ls_gnt_o, 1);
    tick();
    bus.ls_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_stall_req", bus.mem_req_o, 1);
      chk("t2_stall_addr", bus.mem_addr_o, 64'h2008);
      chk("t2_stall_wdata", bus.mem_wdata_o, 64'h55);
      chk("t2_stall_wstrb", bus.mem_wstrb_o, 8'h0F);
      chk("t2_stall_we", bus.mem_we_o, 1);
      tick();
    end
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    chk("t2_req4", bus.mem_req_o, 1);
    tick();
    bus.mem_gnt_i = 1'b0;
    @(negedge clk);
    chk("t2_wait_req", bus.mem_req_o, 0);
    tick();
    bus.mem_rvalid_i = 1'b1;
    @(negedge clk);
    chk("t2_ack", bus.ls_rvalid_o, 1);
    chk("t2_if_rvalid", bus.if_rvalid_o, 0);
    tick();
    clear_in();

    // priority and starvation: 4 LS wins, then IF, repeating
    bus.if_req_i     = 1'b1;
    bus.if_addr_i    = 64'h5000;
    bus.ls_req_i     = 1'b1;
    bus.ls_addr_i    = 64'h6000;
    bus.mem_gnt_i    = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    seq = '0;
    ng  = 0;
    for (int c = 0; c < 40 && ng < 10; c++) begin
      @(negedge clk);
      if (bus.ls_gnt_o) begin
        seq = {seq[8:0], 1'b1};
        ng++;
      end else if (bus.if_gnt_o) begin
        seq = {seq[8:0], 1'b0};
        ng++;
      end
      tick();
    end
    chk("t3_grant_count", 64'(ng), 10);
    chk("t3_grant_order", 64'(seq), 10'b1111011110);
    bus.if_req_i = 1'b0;
    bus.ls_req_i = 1'b0;
    repeat (3) tick();
    clear_in();
    tick();

    // flush during WAIT, then a normal fetch
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 64'h3000;
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    chk("t4_if_gnt", bus.if_gnt_o, 1);
    tick();
    bus.if_req_i = 1'b0;
    tick();
    bus.mem_gnt_i  = 1'b0;
    bus.if_flush_i = 1'b1;
    tick();
    bus.if_flush_i = 1'b0;
    tick();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 64'hAAAA;
    @(negedge clk);
    chk("t4_killed_rvalid", bus.if_rvalid_o, 0);
    chk("t4_killed_rdata", bus.if_rdata_o, 0);
    tick();
    clear_in();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 64'h3008;
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    chk("t4_refetch_gnt", bus.if_gnt_o, 1);
    tick();
    bus.if_req_i = 1'b0;
    @(negedge clk);
    chk("t4_refetch_addr", bus.mem_addr_o, 64'h3008);
    tick();
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 64'h1234;
    @(negedge clk);
    chk("t4_refetch_rvalid", bus.if_rvalid_o, 1);
    chk("t4_refetch_rdata", bus.if_rdata_o, 64'h1234);
    tick();
    clear_in();

    // reset while waiting for the response
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 64'h4000;
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.if_req_i = 1'b0;
    tick();
    bus.mem_gnt_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 64'h77;
    @(negedge clk);
    chk("t5_if_rvalid", bus.if_rvalid_o, 0);
    chk("t5_ls_rvalid", bus.ls_rvalid_o, 0);
    chk("t5_mem_req", bus.mem_req_o, 0);
    chk("t5_mem_addr", bus.mem_addr_o, 0);
    chk("t5_if_rdata", bus.if_rdata_o, 0);
    tick();
    bus.mem_rvalid_i = 1'b0;
    bus.if_req_i     = 1'b1;
    bus.if_addr_i    = 64'h4100;
    @(negedge clk);
    chk("t5_regrant", bus.if_gnt_o, 1);
    tick();
    bus.if_req_i  = 1'b0;
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    @(negedge clk);
    chk("t5_after_rvalid", bus.if_rvalid_o, 1);
    tick();
    clear_in();

    // spurious responses in IDLE and REQ
    bus.mem_rvalid_i = 1'b1;
    @(negedge clk);
    chk("t6_idle_if_rv", bus.if_rvalid_o, 0);
    chk("t6_idle_ls_rv", bus.ls_rvalid_o, 0);
    chk("t6_idle_req", bus.mem_req_o, 0);
    tick();
    bus.ls_req_i  = 1'b1;
    bus.ls_addr_i = 64'h7000;
    @(negedge clk);
    chk("t6_ls_gnt", bus.ls_gnt_o, 1);
    chk("t6_gnt_rv", bus.ls_rvalid_o, 0);
    tick();
    bus.ls_req_i = 1'b0;
    @(negedge clk);
    chk("t6_req_rv", bus.ls_rvalid_o, 0);
    chk("t6_req_hold", bus.mem_req_o, 1);
    tick();
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    chk("t6_req_gnt_rv", bus.ls_rvalid_o, 0);
    tick();
    bus.mem_gnt_i   = 1'b0;
    bus.mem_rdata_i = 64'hCAFE;
    @(negedge clk);
    chk("t6_wait_rv", bus.ls_rvalid_o, 1);
    chk("t6_wait_rdata", bus.ls_rdata_o, 64'hCAFE);
    tick();
    clear_in();
    tick();

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      if (!bus.if_req_i || g_if) begin
        bus.if_req_i  = 1'($urandom % 2);
        bus.if_addr_i = {$urandom, $urandom};
      end
      if (!bus.ls_req_i || g_ls) begin
        bus.ls_req_i   = 1'($urandom % 2);
        bus.ls_we_i    = 1'($urandom % 2);
        bus.ls_addr_i  = {$urandom, $urandom};
        bus.ls_wdata_i = {$urandom, $urandom};
        bus.ls_wstrb_i = 8'($urandom);
      end
      bus.if_flush_i   = ($urandom % 8) == 0;
      bus.mem_gnt_i    = ($urandom % 3) != 0;
      bus.mem_rvalid_i = ($urandom % 3) == 0;
      bus.mem_rdata_i  = {$urandom, $urandom};
      rst              = ($urandom % 150) == 0;
      tick();
    end
    clear_in();
    rst = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
